// File: rtl/axi_dma_pkg.sv
// Shared definitions for the DMA AXI write path: FSM state encoding,
// AXI burst/response constants and a ceil-log2 helper for AWSIZE.
package axi_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_RESP = 3'd3,
    ST_DONE = 3'd4
  } wr_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         AXI_MAX_BURST  = 256;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_dma_wr_skid.sv
// Two-entry FIFO that absorbs the one-cycle data buffer latency so that
// W beats can stall on WREADY without losing prefetched words.
module axi_dma_wr_skid
  #(parameter int WIDTH = 32)
  (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count,
  output logic             empty,
  output logic             full
  );

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == 2'd0);
  assign full      = (count == 2'd2);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Storage, pointers and occupancy; reset flushes contents to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_dma_wr.sv
// AXI4 INCR write-burst master fed by the DMA output data buffer.
// One burst per controller start pulse; words are prefetched into a small
// skid FIFO and streamed on W after the AW handshake. Optional feature:
// define AXI_DMA_WR_RESP_CHK_EN to latch non-OKAY BRESP into a sticky o_err.
module axi_dma_wr
  import axi_dma_pkg::*;
  #(
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32,
  parameter int BIT_TRANS    = 18
  )
  (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_ctrl_write,
  input  logic [AXI_WIDTH_AD-1:0]   i_write_addr,
  input  logic [BIT_TRANS-1:0]      i_num_trans,
  output logic                      o_indata_req_wr,
  input  logic [AXI_WIDTH_DA-1:0]   i_write_data,
  output logic                      o_write_done,
  output logic                      o_busy,
  output logic                      o_err,
  output logic [AXI_WIDTH_AD-1:0]   M_AXI_AWADDR,
  output logic [7:0]                M_AXI_AWLEN,
  output logic [2:0]                M_AXI_AWSIZE,
  output logic [1:0]                M_AXI_AWBURST,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [AXI_WIDTH_DA-1:0]   M_AXI_WDATA,
  output logic [AXI_WIDTH_DA/8-1:0] M_AXI_WSTRB,
  output logic                      M_AXI_WLAST,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY
  );

  localparam int                   STRB_W  = AXI_WIDTH_DA / 8;
  localparam logic [2:0]           AW_SIZE = 3'(clog2(STRB_W));
  localparam logic [BIT_TRANS-1:0] ONE     = BIT_TRANS'(1);

  wr_state_t                 state;
  logic [AXI_WIDTH_AD-1:0]   addr_q;
  logic [7:0]                len_q;
  logic [BIT_TRANS-1:0]      num_q;
  logic [BIT_TRANS-1:0]      req_cnt;
  logic [BIT_TRANS-1:0]      beat_cnt;
  logic                      inflight;
  logic                      awvalid_q;
  logic                      bready_q;
  logic                      done_q;
  logic                      busy_q;

  logic [AXI_WIDTH_DA-1:0]   fifo_head;
  logic [1:0]                fifo_count;
  logic                      fifo_empty;
  logic                      skid_full_unused;

  logic                      wvalid;
  logic                      w_fire;
  logic                      last_beat;
  logic                      fetching;
  logic [2:0]                level;
  logic                      room;
  logic                      req;

  assign wvalid    = (state == ST_DATA) && !fifo_empty;
  assign w_fire    = wvalid && M_AXI_WREADY;
  assign last_beat = (beat_cnt == (num_q - ONE));
  assign fetching  = (state == ST_ADDR) || (state == ST_DATA);
  assign level     = {1'b0, fifo_count} + {2'b00, inflight};
  assign room      = level < (3'd2 + {2'b00, w_fire});
  assign req       = fetching && (req_cnt < num_q) && room;

  assign o_indata_req_wr = req;
  assign o_write_done    = done_q;
  assign o_busy          = busy_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = len_q;
  assign M_AXI_AWSIZE  = awvalid_q ? AW_SIZE : 3'd0;
  assign M_AXI_AWBURST = awvalid_q ? AXI_BURST_INCR : 2'b00;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = fifo_head;
  assign M_AXI_WSTRB   = {STRB_W{wvalid}};
  assign M_AXI_WLAST   = wvalid && last_beat;
  assign M_AXI_WVALID  = wvalid;
  assign M_AXI_BREADY  = bready_q;

  axi_dma_wr_skid #(.WIDTH(AXI_WIDTH_DA)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .pop       (w_fire),
    .push_data (i_write_data),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (skid_full_unused)
  );

  // Prefetch bookkeeping: track issued requests and the word arriving next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      req_cnt  <= '0;
    end else begin
      inflight <= req;
      if (state == ST_IDLE) req_cnt <= '0;
      else if (req)         req_cnt <= req_cnt + ONE;
    end
  end

  // Burst sequencer with registered AW/B handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= 8'd0;
      num_q     <= '0;
      beat_cnt  <= '0;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (i_ctrl_write) begin
            busy_q   <= 1'b1;
            beat_cnt <= '0;
            if (i_num_trans != '0) begin
              addr_q    <= i_write_addr;
              len_q     <= i_num_trans[7:0] - 8'd1;
              num_q     <= i_num_trans;
              awvalid_q <= 1'b1;
              state     <= ST_ADDR;
            end else begin
              num_q  <= '0;
              done_q <= 1'b1;
              state  <= ST_DONE;
            end
          end
        end
        ST_ADDR: begin
          if (M_AXI_AWREADY) begin
            awvalid_q <= 1'b0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_fire) begin
            beat_cnt <= beat_cnt + ONE;
            if (last_beat) begin
              bready_q <= 1'b1;
              state    <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (M_AXI_BVALID) begin
            bready_q <= 1'b0;
            done_q   <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AXI_DMA_WR_RESP_CHK_EN
  logic err_q;

  // Sticky response error: set by a non-OKAY B, cleared by the next accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state == ST_IDLE) && i_ctrl_write) begin
      err_q <= 1'b0;
    end else if ((state == ST_RESP) && M_AXI_BVALID && (M_AXI_BRESP != AXI_RESP_OKAY)) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  logic bresp_unused;
  assign bresp_unused = ^M_AXI_BRESP;
  assign o_err = 1'b0;
`endif

endmodule

// File: doc/axi_dma_wr.md
# axi_dma_wr

AXI4 write-burst master that sits directly downstream of the DMA write controller. On each controller request pulse it issues one INCR burst (AW, W, B channels) at the given DRAM address and pulls beats from the output data buffer. It reports burst completion back to the controller with a one-cycle done pulse.

## Interface
- AXI_WIDTH_AD, 32, AXI address width
- AXI_WIDTH_DA, 32, AXI data width; one beat per buffer word
- BIT_TRANS, 18, width of the beat-count input
- clk  in  1  clock; one clock domain, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- i_ctrl_write  in  1  start pulse; sampled only in IDLE
- i_write_addr  in  AXI_WIDTH_AD  burst start byte address; latched with i_ctrl_write
- i_num_trans  in  BIT_TRANS  beats in burst, legal 0..256; latched with i_ctrl_write
- o_indata_req_wr  out  1  pop request to data buffer; data returns exactly 1 cycle later
- i_write_data  in  AXI_WIDTH_DA  buffer data, valid the cycle after o_indata_req_wr
- o_write_done  out  1  one-cycle pulse at burst completion
- o_busy  out  1  high whenever FSM is not IDLE
- o_err  out  1  write-response error flag (see Configuration)
- M_AXI_AWADDR out AXI_WIDTH_AD; M_AXI_AWLEN out 8; M_AXI_AWSIZE out 3; M_AXI_AWBURST out 2; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1
- M_AXI_WDATA out AXI_WIDTH_DA; M_AXI_WSTRB out AXI_WIDTH_DA/8; M_AXI_WLAST out 1; M_AXI_WVALID out 1; M_AXI_WREADY in 1
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1

## Operation
- FSM states: IDLE, ADDR, DATA, RESP, DONE.
- IDLE: i_ctrl_write with i_num_trans != 0 -> latch address/count, go ADDR; with i_num_trans == 0 -> go DONE, no AXI traffic.
- ADDR: AWVALID high; AWADDR = latched address, AWLEN = num_trans-1 (low 8 bits), AWSIZE = log2(AXI_WIDTH_DA/8), AWBURST = 2'b01 (INCR). On AWREADY -> DATA.
- DATA: WVALID high while skid FIFO not empty; WDATA = FIFO head; WSTRB all ones; WLAST on beat num_trans-1. Pop on WVALID&WREADY. Last beat accepted -> RESP.
- RESP: BREADY high; on BVALID -> DONE.
- DONE: o_write_done = 1 for one cycle -> IDLE.
- Prefetch: o_indata_req_wr asserted in ADDR and DATA when requests issued < num_trans and (fifo_count + inflight_req - pop_this_cycle) < 2. Never over-requests past num_trans.
- i_ctrl_write outside IDLE is ignored.
- AXI VALID signals, once high, remain high and payload stable until READY.
- Beat counters BIT_TRANS wide; values above 256 are illegal (AWLEN truncates, behaviour undefined).

## Timing
- Reset values: every output 0 (including AWVALID, WVALID, BREADY, o_indata_req_wr, o_write_done, o_busy, o_err); FSM IDLE; FIFO flushed.
- Reset mid-burst: immediate return to IDLE next cycle, AXI transaction abandoned; slave reset with system.
- i_ctrl_write at cycle 0 -> AWVALID and first o_indata_req_wr at cycle 1; first data in FIFO at cycle 2.
- W never asserted before AW handshake completes.
- Sustained throughput 1 beat/cycle with WREADY held high.
- o_write_done exactly 1 cycle after B handshake cycle; zero-length request -> o_write_done at cycle 1.
- WREADY low stalls pops; prefetch stops at 2 buffered+inflight; no data lost.

## Configuration
- AXI_DMA_WR_RESP_CHK_EN defined: BRESP != 2'b00 at B handshake sets o_err; o_err sticky until next accepted i_ctrl_write or rst.
- Undefined: BRESP ignored, o_err tied 0.

## Structure
- Package axi_dma_pkg: FSM state encoding, AXI_BURST_INCR, AXI_RESP_OKAY, AXI max burst length (256), clog2 helper for AWSIZE.
- Sub-module axi_dma_wr_skid: 2-entry FIFO (push, pop, data, count, empty, full) decoupling 1-cycle buffer latency from WREADY.

## Test plan
- rst, then i_ctrl_write addr 0x1000_0040, num_trans 16, all READY high -> AWADDR 0x1000_0040, AWLEN 15, AWSIZE 2, 16 beats on consecutive cycles, WLAST on 16th, o_write_done 1 cycle after BVALID.
- Same burst with WREADY toggling 1-0 and held low 5 cycles mid-burst -> data order preserved, exactly 16 o_indata_req_wr pulses, no FIFO overflow.
- i_num_trans 0 -> o_write_done at cycle 1, no AWVALID ever.
- AWREADY delayed 10 cycles -> AWVALID/AWADDR stable, at most 2 prefetch requests, WVALID low until handshake.
- BRESP 2'b10 with AXI_DMA_WR_RESP_CHK_EN -> o_err high until next i_ctrl_write; without macro -> o_err stays 0.
- rst asserted on beat 7 of 16 -> next cycle all outputs 0, FSM IDLE; new 4-beat request then completes normally.
